// File: rtl/corner_capture_if.sv
// Bundles the corner-capture data path into one interface: the address-valid
// strobe and pixel stream from the frame BRAM side, the dark threshold, and
// the corner buffer read port with its status outputs.
//   master : the producer/consumer around the block (drives strobes, reads back)
//   slave  : corner_capture itself
interface corner_capture_if #(
   parameter int PIXEL_W   = 8,
   parameter int BUF_DEPTH = 4096
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic               addr_valid_in;
   logic [PIXEL_W-1:0] pixel_in;
   logic [PIXEL_W-1:0] threshold_in;
   logic [AW-1:0]      rd_addr_in;
   logic [PIXEL_W-1:0] rd_data_out;
   logic [CW-1:0]      pixel_count;
   logic [CW-1:0]      dark_count;
   logic               capture_done;
   logic               busy;
   logic               overflow;

   modport master (
      output addr_valid_in, pixel_in, threshold_in, rd_addr_in,
      input  rd_data_out, pixel_count, dark_count, capture_done, busy, overflow
   );

   modport slave (
      input  addr_valid_in, pixel_in, threshold_in, rd_addr_in,
      output rd_data_out, pixel_count, dark_count, capture_done, busy, overflow
   );
endinterface

// File: rtl/corner_capture.sv
// Captures a burst of corner pixels read from the frame BRAM into a local
// buffer, counting stored pixels and those darker than a latched threshold.
// Ports:
//   clk_in  : system clock
//   rst_in  : asynchronous active-high reset
//   bus     : corner_capture_if.slave (addr_valid_in, pixel_in, threshold_in,
//             rd_addr_in in; rd_data_out, pixel_count, dark_count,
//             capture_done, busy, overflow out)
//
// state   | meaning
// IDLE    | waiting for a rising edge of addr_valid_in
// CAPTURE | address generator active, storing delayed pixels
// DRAIN   | READ_LATENCY cycles collecting pixels still in the BRAM pipe
// DONE    | one-cycle capture_done pulse
module corner_capture #(
   parameter int HEIGHT       = 320,
   parameter int WIDTH        = 240,
   parameter int PIXEL_W      = 8,
   parameter int READ_LATENCY = 2,
   parameter int BUF_DEPTH    = 4096
) (
   input  logic             clk_in,
   input  logic             rst_in,
   corner_capture_if.slave  bus
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int DW = $clog2(READ_LATENCY + 1);
   localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(READ_LATENCY - 1);

   // Frame geometry only describes the pixel source; a degenerate
   // configuration is flagged by this empty block in the elaborated hierarchy.
   if (READ_LATENCY < 1 || HEIGHT * WIDTH < 1) begin : g_bad_config
   end

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic                    av_prev_q;
   // The write pointer always equals the stored-pixel count, so one register
   // serves both.
   logic [CW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           dark_q, dark_d;
   logic                    ovf_q, ovf_d;
   logic [PIXEL_W-1:0]      thr_q, thr_d;
   logic [PIXEL_W-1:0]      rd_data_q, rd_data_d;
   logic [DW-1:0]           drain_q, drain_d;
   logic                    pix_valid;
   logic                    start;
   logic                    wr_en;

   logic [PIXEL_W-1:0]      buf_mem [BUF_DEPTH];

   assign pix_valid = vld_sr_q[READ_LATENCY-1];
   assign start     = bus.addr_valid_in & ~av_prev_q;

   always_comb begin
      vld_sr_d    = vld_sr_q << 1;
      vld_sr_d[0] = bus.addr_valid_in;
   end

   // Addresses at or beyond the stored count read as 0; this also covers a
   // read of the slot being written this cycle.
   always_comb begin
      rd_data_d = '0;
      if (CW'(bus.rd_addr_in) < ptr_q) rd_data_d = buf_mem[bus.rd_addr_in];
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      ptr_d   = ptr_q;
      dark_d  = dark_q;
      ovf_d   = ovf_q;
      thr_d   = thr_q;
      wr_en   = 1'b0;

      if ((state_q == CAPTURE || state_q == DRAIN) && pix_valid) begin
         if (ptr_q < DEPTH_C) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (bus.pixel_in < thr_q) dark_d = dark_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CAPTURE;
               ptr_d   = '0;
               dark_d  = '0;
               ovf_d   = 1'b0;
               thr_d   = bus.threshold_in;
            end
         end
         CAPTURE: begin
            if (!bus.addr_valid_in) begin
               state_d = DRAIN;
               drain_d = DRAIN_LAST;
            end
         end
         DRAIN: begin
            if (drain_q == '0) state_d = DONE;
            else               drain_d = drain_q - 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         vld_sr_q  <= '0;
         av_prev_q <= 1'b0;
         ptr_q     <= '0;
         dark_q    <= '0;
         ovf_q     <= 1'b0;
         thr_q     <= '0;
         rd_data_q <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         vld_sr_q  <= vld_sr_d;
         av_prev_q <= bus.addr_valid_in;
         ptr_q     <= ptr_d;
         dark_q    <= dark_d;
         ovf_q     <= ovf_d;
         thr_q     <= thr_d;
         rd_data_q <= rd_data_d;
         drain_q   <= drain_d;
      end
   end

   // Buffer contents survive reset; the zeroed count hides stale entries.
   always_ff @(posedge clk_in) begin
      if (wr_en) buf_mem[ptr_q[AW-1:0]] <= bus.pixel_in;
   end

   assign bus.rd_data_out  = rd_data_q;
   assign bus.pixel_count  = ptr_q;
   assign bus.dark_count   = dark_q;
   assign bus.overflow     = ovf_q;
   assign bus.capture_done = (state_q == DONE);
   assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_corner_capture.sv
module tb_corner_capture;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        av = 1'b0;
   logic [7:0]  pix = 8'd0;
   logic [7:0]  thr = 8'd0;
   logic [11:0] rd_addr = 12'd0;
   logic [2:0]  rd_addr8 = 3'd0;

   int total = 0;
   int bad   = 0;
   int done_cnt, done_at, done8_cnt;
   logic       busy_c1;
   logic       snap_ovf8;
   logic [3:0] snap_cnt8;

   corner_capture_if #(.PIXEL_W(8), .BUF_DEPTH(4096)) bus ();
   corner_capture_if #(.PIXEL_W(8), .BUF_DEPTH(8))    bus8 ();

   assign bus.addr_valid_in  = av;
   assign bus.pixel_in       = pix;
   assign bus.threshold_in   = thr;
   assign bus.rd_addr_in     = rd_addr;
   assign bus8.addr_valid_in = av;
   assign bus8.pixel_in      = pix;
   assign bus8.threshold_in  = thr;
   assign bus8.rd_addr_in    = rd_addr8;

   corner_capture #(.HEIGHT(320), .WIDTH(240), .PIXEL_W(8), .READ_LATENCY(2),
                    .BUF_DEPTH(4096)) dut (
      .clk_in(clk), .rst_in(rst), .bus(bus));

   corner_capture #(.HEIGHT(320), .WIDTH(240), .PIXEL_W(8), .READ_LATENCY(2),
                    .BUF_DEPTH(8)) dut8 (
      .clk_in(clk), .rst_in(rst), .bus(bus8));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives av from a bit pattern (bit c = cycle c); the BRAM model presents
   // pix_base + (c-2) in cycle c, i.e. two cycles after the matching address.
   task automatic run_seq(input int ncyc, input logic [31:0] av_pat,
                          input int pix_base, input logic [7:0] thr0,
                          input logic [7:0] thr1);
      done_cnt  = 0;
      done_at   = -1;
      done8_cnt = 0;
      for (int c = 0; c < ncyc; c++) begin
         av  = (c < 32) ? av_pat[c] : 1'b0;
         thr = (c == 0) ? thr0 : thr1;
         pix = (c >= 2) ? 8'(pix_base + c - 2) : 8'hEE;
         tick();
         if (bus.capture_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = c + 1;
         end
         if (bus8.capture_done === 1'b1) done8_cnt++;
         if (c == 0) busy_c1 = bus.busy;
         if (c == 1) begin
            snap_ovf8 = bus8.overflow;
            snap_cnt8 = bus8.pixel_count;
         end
      end
      av = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      total++; if (bus.rd_data_out !== 8'd0) begin bad++; $display("FAIL rst_rd_data got=%0d want=0", bus.rd_data_out); end
      total++; if (bus.pixel_count !== 13'd0) begin bad++; $display("FAIL rst_pixel_count got=%0d want=0", bus.pixel_count); end
      total++; if (bus.dark_count !== 13'd0) begin bad++; $display("FAIL rst_dark_count got=%0d want=0", bus.dark_count); end
      total++; if (bus.capture_done !== 1'b0) begin bad++; $display("FAIL rst_capture_done got=%b want=0", bus.capture_done); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", bus.overflow); end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      // threshold 15 latched at start; threshold_in changes to 100 afterwards
      run_seq(16, 32'h0000_0FFF, 10, 8'd15, 8'd100);
      total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=%b want=1", busy_c1); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
      total++; if (done_at !== 15) begin bad++; $display("FAIL basic_done_cycle got=%0d want=15", done_at); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", bus.busy); end
      total++; if (bus.pixel_count !== 13'd12) begin bad++; $display("FAIL basic_pixel_count got=%0d want=12", bus.pixel_count); end
      total++; if (bus.dark_count !== 13'd5) begin bad++; $display("FAIL basic_dark_count got=%0d want=5", bus.dark_count); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b want=0", bus.overflow); end
   endtask

   task automatic test_read();
      rd_addr = 12'd3; tick();
      total++; if (bus.rd_data_out !== 8'd13) begin bad++; $display("FAIL read_addr3 got=%0d want=13", bus.rd_data_out); end
      rd_addr = 12'd12; tick();
      total++; if (bus.rd_data_out !== 8'd0) begin bad++; $display("FAIL read_addr12 got=%0d want=0", bus.rd_data_out); end
      rd_addr = 12'd11; tick();
      total++; if (bus.rd_data_out !== 8'd21) begin bad++; $display("FAIL read_addr11 got=%0d want=21", bus.rd_data_out); end
      rd_addr = 12'd0; tick();
      total++; if (bus.rd_data_out !== 8'd10) begin bad++; $display("FAIL read_addr0 got=%0d want=10", bus.rd_data_out); end
   endtask

   task automatic test_overflow();
      run_seq(16, 32'h0000_03FF, 1, 8'd100, 8'd100);
      total++; if (done8_cnt !== 1) begin bad++; $display("FAIL ovf_done_pulses got=%0d want=1", done8_cnt); end
      total++; if (bus8.pixel_count !== 4'd8) begin bad++; $display("FAIL ovf_pixel_count got=%0d want=8", bus8.pixel_count); end
      total++; if (bus8.dark_count !== 4'd8) begin bad++; $display("FAIL ovf_dark_count got=%0d want=8", bus8.dark_count); end
      total++; if (bus8.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus8.overflow); end
      total++; if (bus.pixel_count !== 13'd10) begin bad++; $display("FAIL ovf_big_count got=%0d want=10", bus.pixel_count); end
      rd_addr8 = 3'd7; tick();
      total++; if (bus8.rd_data_out !== 8'd8) begin bad++; $display("FAIL ovf_read7 got=%0d want=8", bus8.rd_data_out); end
      tick();
      total++; if (bus8.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus8.overflow); end
      run_seq(10, 32'h0000_0007, 50, 8'd100, 8'd100);
      total++; if (snap_ovf8 !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start got=%b want=0", snap_ovf8); end
      total++; if (snap_cnt8 !== 4'd0) begin bad++; $display("FAIL ovf_count_clear got=%0d want=0", snap_cnt8); end
      total++; if (bus8.pixel_count !== 4'd3) begin bad++; $display("FAIL ovf_next_count got=%0d want=3", bus8.pixel_count); end
      rd_addr8 = 3'd3; tick();
      total++; if (bus8.rd_data_out !== 8'd0) begin bad++; $display("FAIL ovf_read_stale got=%0d want=0", bus8.rd_data_out); end
      rd_addr8 = 3'd2; tick();
      total++; if (bus8.rd_data_out !== 8'd52) begin bad++; $display("FAIL ovf_read2 got=%0d want=52", bus8.rd_data_out); end
   endtask

   task automatic test_reset_mid();
      run_seq(7, 32'h0000_03FF, 40, 8'd45, 8'd45);
      av = 1'b1;
      total++; if (bus.pixel_count !== 13'd5) begin bad++; $display("FAIL mid_pre_count got=%0d want=5", bus.pixel_count); end
      rst = 1'b1;
      #1;
      total++; if (bus.pixel_count !== 13'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", bus.pixel_count); end
      total++; if (bus.dark_count !== 13'd0) begin bad++; $display("FAIL mid_rst_dark got=%0d want=0", bus.dark_count); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", bus.busy); end
      total++; if (bus.rd_data_out !== 8'd0) begin bad++; $display("FAIL mid_rst_rd_data got=%0d want=0", bus.rd_data_out); end
      tick();
      total++; if (bus.capture_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", bus.capture_done); end
      av = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      total++; if (bus.capture_done !== 1'b0 || done_cnt !== 0) begin bad++; $display("FAIL mid_no_done got=%b/%0d want=0/0", bus.capture_done, done_cnt); end
      run_seq(10, 32'h0000_000F, 60, 8'd62, 8'd62);
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_new_done got=%0d want=1", done_cnt); end
      total++; if (bus.pixel_count !== 13'd4) begin bad++; $display("FAIL mid_new_count got=%0d want=4", bus.pixel_count); end
      total++; if (bus.dark_count !== 13'd2) begin bad++; $display("FAIL mid_new_dark got=%0d want=2", bus.dark_count); end
   endtask

   task automatic test_back_to_back();
      // 4 high, 1 low, 4 high: second burst begins in DRAIN and is ignored
      run_seq(14, 32'h0000_01EF, 30, 8'd32, 8'd32);
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=1", done_cnt); end
      total++; if (done_at !== 7) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=7", done_at); end
      total++; if (bus.pixel_count !== 13'd4) begin bad++; $display("FAIL b2b_pixel_count got=%0d want=4", bus.pixel_count); end
      total++; if (bus.dark_count !== 13'd2) begin bad++; $display("FAIL b2b_dark_count got=%0d want=2", bus.dark_count); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", bus.busy); end
      rd_addr = 12'd3; tick();
      total++; if (bus.rd_data_out !== 8'd33) begin bad++; $display("FAIL b2b_read3 got=%0d want=33", bus.rd_data_out); end
      rd_addr = 12'd4; tick();
      total++; if (bus.rd_data_out !== 8'd0) begin bad++; $display("FAIL b2b_read4 got=%0d want=0", bus.rd_data_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_read();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/corner_capture.md
CORNER_CAPTURE -- requirements
Module: corner_capture

Interface
REQ-001 Parameters SHALL be: HEIGHT, default 320, frame height in pixels; WIDTH, default 240, frame width in pixels; PIXEL_W, default 8, grayscale pixel width; READ_LATENCY, default 2, frame-BRAM read latency in cycles (>=1); BUF_DEPTH, default 4096, corner buffer entries.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk_in  input  1  system clock.
REQ-004 rst_in  input  1  asynchronous active-high reset.
REQ-005 addr_valid_in  input  1  high in each cycle the address generator issued one corner pixel address to the frame BRAM.
REQ-006 pixel_in  input  PIXEL_W  frame BRAM read data, valid READ_LATENCY cycles after the matching addr_valid_in cycle.
REQ-007 threshold_in  input  PIXEL_W  dark-pixel threshold.
REQ-008 rd_addr_in  input  $clog2(BUF_DEPTH)  corner buffer read address.
REQ-009 rd_data_out  output  PIXEL_W  corner buffer read data.
REQ-010 pixel_count  output  $clog2(BUF_DEPTH+1)  pixels stored in the current or last capture.
REQ-011 dark_count  output  $clog2(BUF_DEPTH+1)  stored pixels strictly below the threshold.
REQ-012 capture_done  output  1  one-cycle pulse when a capture completes.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overflow  output  1  sticky flag: a pixel was dropped because the buffer was full.

Function
REQ-015 Delayed valid: a READ_LATENCY-deep shift register of addr_valid_in SHALL produce the tap pix_valid; pixel_in is consumed only in cycles where pix_valid=1.
REQ-016 FSM states SHALL be IDLE, CAPTURE, DRAIN and DONE.
REQ-017 IDLE->CAPTURE SHALL occur only on a rising edge of addr_valid_in (high now, low in the previous cycle) while in IDLE; a level that is already high on return to IDLE SHALL be ignored.
REQ-018 On capture start: write pointer, pixel_count, dark_count and overflow SHALL clear to 0, and threshold_in SHALL be latched for the whole capture.
REQ-019 CAPTURE->DRAIN SHALL occur in the first cycle addr_valid_in is low.
REQ-020 DRAIN SHALL last exactly READ_LATENCY cycles, keeping pix_valid processing active, then go to DONE.
REQ-021 DONE SHALL last one cycle with capture_done=1, then go to IDLE.
REQ-022 Rising edges of addr_valid_in in DRAIN or DONE SHALL be ignored.
REQ-023 Per pix_valid cycle with pointer < BUF_DEPTH: write pixel_in to buf[pointer]; increment pointer and pixel_count; increment dark_count if pixel_in < latched threshold.
REQ-024 Per pix_valid cycle with pointer == BUF_DEPTH: drop the pixel, set overflow=1, and hold both counts (saturate).
REQ-025 Read port: rd_data_out SHALL be registered with 1-cycle latency; it returns buf[rd_addr_in] if rd_addr_in < pixel_count, else 0.
REQ-026 Reads SHALL be legal in any state; a read of the address being written in the same cycle returns the old content or 0.
REQ-027 Counts and overflow SHALL hold after DONE until the next capture start.

Reset
REQ-028 While rst_in=1, asynchronously: state=IDLE; rd_data_out, pixel_count, dark_count, capture_done, busy, overflow, pointer and valid shift register all 0.
REQ-029 Buffer contents need not be cleared; reads return 0 because pixel_count=0.
REQ-030 Reset mid-capture SHALL abort with no capture_done pulse; the next rising edge of addr_valid_in after release starts a fresh capture.

Verification (READ_LATENCY=2)
REQ-031 Assert rst_in with no clock edge -> all outputs 0 immediately; busy=0.
REQ-032 threshold_in=15; addr_valid_in high 12 cycles; pixel_in=10..21 on the delayed cycles -> pixel_count=12, dark_count=5, capture_done high exactly 1 cycle, 3 cycles after addr_valid_in falls; busy=0 the following cycle.
REQ-033 After REQ-032: rd_addr_in=3 -> rd_data_out=13 next cycle; rd_addr_in=12 -> rd_data_out=0.
REQ-034 BUF_DEPTH=8; 10-pixel capture of values 1..10 -> pixel_count=8, overflow=1, rd_addr_in=7 returns 8; the next capture start clears overflow.
REQ-035 Reset asserted after 5 pixels stored -> counts 0, no capture_done; a new 4-pixel burst -> pixel_count=4.
REQ-036 addr_valid_in: 4 cycles high, 1 low, 4 high -> one capture, pixel_count=4, capture_done once; the second burst is ignored because it starts in DRAIN and is still high on return to IDLE.
